mips_cache_controller: RTL

//  Miss-handling and write-through engine between the data cache and the Avalon memory bus.
//  On a cache miss it fetches the missing word over Avalon.
//  It returns the word to the cache with a one-cycle data_valid strobe.
//  CPU writes that complete in the cache are posted into an in-order write buffer.
//  The buffer drains to memory in the background; wbuf_full back-pressures the CPU.

---
 rtl/mips_cache_controller.sv | 117 +++++++++++
 1 files changed

// File: rtl/mips_cache_controller.sv
// rtl/mips_cache_controller.sv - data cache miss fetch and posted write-through engine on Avalon
module mips_cache_controller #(
    parameter int WBUF_DEPTH = 4,
    parameter int WBUF_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss,
    input  logic [31:0] miss_addr,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byte_en,
    output logic [31:0] data_in,
    output logic        data_valid,
    output logic        wbuf_full,
    output logic        busy,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [1:0] {IDLE, DRAIN, READ, FILL} state_t;

    localparam logic [WBUF_BITS:0] DEPTH_CNT = (WBUF_BITS+1)'(WBUF_DEPTH);

    state_t               state;
    logic [31:0]          fifo_addr [WBUF_DEPTH];
    logic [31:0]          fifo_data [WBUF_DEPTH];
    logic [3:0]           fifo_be   [WBUF_DEPTH];
    logic [WBUF_BITS-1:0] wr_ptr;
    logic [WBUF_BITS-1:0] rd_ptr;
    logic [WBUF_BITS:0]   count;
    logic                 enq;
    logic                 pop;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^miss_addr[1:0];

    assign wbuf_full = (count == DEPTH_CNT);
    assign busy      = (state != IDLE) || (count != '0);
    assign enq       = cpu_write_en && !miss && !wbuf_full;
    assign pop       = (state == DRAIN) && !avm_waitrequest;

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= {miss_addr[31:2], 2'b00};
            fifo_data[wr_ptr] <= cpu_writedata;
            fifo_be[wr_ptr]   <= cpu_byte_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_in        <= '0;
            data_valid     <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Posted stores go out before any fetch so memory stays in program order.
                    if (count != '0) begin
                        state          <= DRAIN;
                        avm_write      <= 1'b1;
                        avm_address    <= fifo_addr[rd_ptr];
                        avm_writedata  <= fifo_data[rd_ptr];
                        avm_byteenable <= fifo_be[rd_ptr];
                    end else if (miss && (cpu_read_en || cpu_write_en)) begin
                        state          <= READ;
                        avm_read       <= 1'b1;
                        avm_address    <= {miss_addr[31:2], 2'b00};
                        avm_byteenable <= 4'b1111;
                    end
                end
                DRAIN: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= IDLE;
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        avm_read   <= 1'b0;
                        data_in    <= avm_readdata;
                        data_valid <= 1'b1;
                        state      <= FILL;
                    end
                end
                FILL: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
